// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing one block-level SD port among NUM virtual-drive requesters.
// Latency: request at edge n -> sd_rd/sd_wr after edge n; ack to requester one edge after sd_ack; buffer path combinational.
// Backpressure: requests are level-held until acked; the grant is held for the whole sector and ignores other requesters.
module sd_block_arbiter #(
  parameter int NUM = 2,
  parameter int AW  = 8,
  parameter int DW  = 7
) (
  input  logic                  clk_sys,
  input  logic                  reset,

  input  logic [32*NUM-1:0]     req_lba,
  input  logic [NUM-1:0]        req_rd,
  input  logic [NUM-1:0]        req_wr,
  output logic [NUM-1:0]        req_ack,
  input  logic [(DW+1)*NUM-1:0] req_buff_din,
  output logic [AW:0]           req_buff_addr,
  output logic [DW:0]           req_buff_dout,
  output logic [NUM-1:0]        req_buff_wr,

  output logic [31:0]           sd_lba,
  output logic                  sd_rd,
  output logic                  sd_wr,
  input  logic                  sd_ack,
  input  logic [AW:0]           sd_buff_addr,
  input  logic [DW:0]           sd_buff_dout,
  input  logic                  sd_buff_wr,
  output logic [DW:0]           sd_buff_din,

  output logic [1:0]            grant_idx,
  output logic                  busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

  state_t      state;
  logic [1:0]  rr;

  // Requester signals padded to four slots so grant_idx can index them directly.
  logic [3:0]  rd_pad;
  logic [3:0]  wr_pad;
  logic [3:0]  cand;
  logic [31:0] lba_arr [4];
  logic [DW:0] din_arr [4];
  logic [NUM-1:0] grant_sel;

  logic        win_vld;
  logic [1:0]  win_idx;

  assign rd_pad = 4'(req_rd);
  assign wr_pad = 4'(req_wr);
  assign cand   = rd_pad | wr_pad;

  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < NUM) begin : g_live
      assign lba_arr[g] = req_lba[32*g +: 32];
      assign din_arr[g] = req_buff_din[(DW+1)*g +: (DW+1)];
    end else begin : g_tie
      assign lba_arr[g] = '0;
      assign din_arr[g] = '0;
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : g_sel
    assign grant_sel[g]   = (grant_idx == 2'(g));
    assign req_buff_wr[g] = sd_buff_wr & busy & grant_sel[g];
  end

  // Buffer address/data are broadcast; only the write strobe is steered.
  assign req_buff_addr = sd_buff_addr;
  assign req_buff_dout = sd_buff_dout;
  assign sd_buff_din   = din_arr[grant_idx];

  // Slot reached k steps after base, wrapping at NUM (base < NUM, k <= NUM).
  function automatic logic [1:0] rr_step(input logic [1:0] base, input int k);
    int t;
    t = int'(base) + k;
    if (t >= NUM) t = t - NUM;
    return t[1:0];
  endfunction

  // Pick the first pending requester starting just after the last served one;
  // scanning from the far end lets the nearest candidate overwrite the others.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM; k >= 1; k--) begin
      if (cand[rr_step(rr, k)]) begin
        win_vld = 1'b1;
        win_idx = rr_step(rr, k);
      end
    end
  end

  // Grant / handshake state machine with registered bridge-side and requester-side outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      sd_lba    <= '0;
      req_ack   <= '0;
      grant_idx <= '0;
      rr        <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A stray sd_ack here is deliberately ignored.
          if (win_vld) begin
            grant_idx <= win_idx;
            sd_lba    <= lba_arr[win_idx];
            sd_rd     <= rd_pad[win_idx];
            sd_wr     <= wr_pad[win_idx] & ~rd_pad[win_idx];
            state     <= ST_REQ;
            busy      <= 1'b1;
          end
        end
        ST_REQ: begin
          if (sd_ack) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            req_ack <= grant_sel;
            state   <= ST_XFER;
          end else if (!(rd_pad[grant_idx] | wr_pad[grant_idx])) begin
            // Requester withdrew before the bridge answered; rr stays put
            // so the aborted slot keeps its place in the rotation.
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_XFER: begin
          if (!sd_ack) begin
            req_ack <= '0;
            rr      <= grant_idx;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_arbiter.sv
module tb_sd_block_arbiter;

  localparam int NUM = 2;
  localparam int AW  = 8;
  localparam int DW  = 7;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b0;
  logic [63:0] req_lba;
  logic [1:0]  req_rd, req_wr, req_ack, req_buff_wr;
  logic [15:0] req_buff_din;
  logic [8:0]  req_buff_addr, sd_buff_addr;
  logic [7:0]  req_buff_dout, sd_buff_dout, sd_buff_din;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [1:0]  grant_idx;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  sd_block_arbiter #(.NUM(NUM), .AW(AW), .DW(DW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr), .req_ack(req_ack),
    .req_buff_din(req_buff_din), .req_buff_addr(req_buff_addr),
    .req_buff_dout(req_buff_dout), .req_buff_wr(req_buff_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 = idle, 1 = waiting for bridge ack, 2 = sector transfer
  int          m_st   = 0;
  logic        m_rd   = 1'b0;
  logic        m_wr   = 1'b0;
  logic [31:0] m_lba  = '0;
  logic [1:0]  m_ack  = '0;
  int          m_g    = 0;
  int          m_rr   = 0;

  function automatic bit pick(input logic [1:0] v, input int i);
    return ((v >> i) & 2'b01) != 2'b00;
  endfunction

  task automatic model_edge();
    int w;
    logic [1:0] cand;
    cand = req_rd | req_wr;
    case (m_st)
      0: begin
        w = -1;
        for (int k = 1; k <= NUM; k++) begin
          if (w < 0 && pick(cand, (m_rr + k) % NUM)) w = (m_rr + k) % NUM;
        end
        if (w >= 0) begin
          m_g   = w;
          m_lba = 32'(req_lba >> (32 * w));
          m_rd  = pick(req_rd, w);
          m_wr  = pick(req_wr, w) && !pick(req_rd, w);
          m_st  = 1;
        end
      end
      1: begin
        if (sd_ack) begin
          m_rd = 1'b0; m_wr = 1'b0; m_ack = 2'(1 << m_g); m_st = 2;
        end else if (!pick(cand, m_g)) begin
          m_rd = 1'b0; m_wr = 1'b0; m_st = 0;
        end
      end
      default: begin
        if (!sd_ack) begin
          m_ack = 2'b00; m_rr = m_g; m_st = 0;
        end
      end
    endcase
  endtask

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      m_st = 0; m_rd = 1'b0; m_wr = 1'b0; m_lba = '0; m_ack = '0; m_g = 0; m_rr = 0;
    end else begin
      model_edge();
    end
  end

  // Every cycle, mid-period: all outputs against the model.
  always @(negedge clk_sys) begin
    chk("sd_rd", 64'(sd_rd), 64'(m_rd));
    chk("sd_wr", 64'(sd_wr), 64'(m_wr));
    chk("sd_lba", 64'(sd_lba), 64'(m_lba));
    chk("req_ack", 64'(req_ack), 64'(m_ack));
    chk("grant_idx", 64'(grant_idx), 64'(m_g));
    chk("busy", 64'(busy), 64'(m_st != 0));
    chk("req_buff_wr", 64'(req_buff_wr),
        64'((sd_buff_wr && m_st != 0) ? 2'(1 << m_g) : 2'b00));
    chk("sd_buff_din", 64'(sd_buff_din), 64'(8'(req_buff_din >> (8 * m_g))));
    chk("req_buff_addr", 64'(req_buff_addr), 64'(sd_buff_addr));
    chk("req_buff_dout", 64'(req_buff_dout), 64'(sd_buff_dout));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic serve(output int g);
    int n;
    n = 0;
    while (!(sd_rd || sd_wr) && n < 10) begin
      tick();
      n++;
    end
    chk("serve_req_seen", 64'(sd_rd | sd_wr), 64'd1);
    g = int'(grant_idx);
    sd_ack = 1'b1;
    tick();
    tick();
    sd_ack = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt0, cnt1, g, kind;
    logic [1:0] bm;
    req_lba = '0; req_rd = '0; req_wr = '0; req_buff_din = '0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #2;
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sd_rd", 64'(sd_rd), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_req_ack", 64'(req_ack), 64'd0);

    // single read from requester 0, 512-byte sector
    req_lba[31:0] = 32'h0000_1234;
    req_rd = 2'b01;
    tick();
    chk("t1_sd_rd", 64'(sd_rd), 64'd1);
    chk("t1_sd_lba", 64'(sd_lba), 64'h1234);
    chk("t1_busy", 64'(busy), 64'd1);
    sd_ack = 1'b1;
    tick();
    chk("t1_sd_rd_clr", 64'(sd_rd), 64'd0);
    chk("t1_req_ack", 64'(req_ack), 64'b01);
    req_rd = 2'b00;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 512; i++) begin
      sd_buff_wr = 1'b1;
      sd_buff_addr = 9'(i);
      sd_buff_dout = 8'(i * 7);
      #1;
      if (req_buff_wr[0]) cnt0++;
      if (req_buff_wr[1]) cnt1++;
      tick();
    end
    sd_buff_wr = 1'b0;
    chk("t1_wr0_count", 64'(cnt0), 64'd512);
    chk("t1_wr1_count", 64'(cnt1), 64'd0);
    sd_ack = 1'b0;
    tick();
    chk("t1_ack_clr", 64'(req_ack), 64'd0);
    chk("t1_busy_clr", 64'(busy), 64'd0);

    // contention from reset: grants alternate starting with requester 1
    do_reset();
    req_rd = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(g);
      chk("t2_grant_order", 64'(g), 64'((i % 2 == 0) ? 1 : 0));
    end
    req_rd = 2'b00;
    tick();

    // write mux and read-over-write priority
    do_reset();
    req_buff_din = {8'hA5, 8'h3C};
    req_lba[63:32] = 32'hCAFE_0001;
    req_wr = 2'b10;
    tick();
    chk("t3_sd_wr", 64'(sd_wr), 64'd1);
    chk("t3_sd_rd", 64'(sd_rd), 64'd0);
    chk("t3_grant", 64'(grant_idx), 64'd1);
    chk("t3_lba", 64'(sd_lba), 64'hCAFE_0001);
    sd_ack = 1'b1;
    tick();
    #1;
    chk("t3_buff_din", 64'(sd_buff_din), 64'hA5);
    req_wr = 2'b00;
    sd_ack = 1'b0;
    tick();
    req_rd = 2'b10; req_wr = 2'b10;
    tick();
    chk("t3_both_rd", 64'(sd_rd), 64'd1);
    chk("t3_both_wr", 64'(sd_wr), 64'd0);
    sd_ack = 1'b1;
    tick();
    req_rd = 2'b00; req_wr = 2'b00; sd_ack = 1'b0;
    tick();

    // abort before ack: rr (=1 here) must not move
    req_lba[31:0] = 32'h0BAD_0000;
    req_rd = 2'b01;
    tick();
    chk("t4_grant0", 64'(grant_idx), 64'd0);
    chk("t4_sd_rd", 64'(sd_rd), 64'd1);
    req_rd = 2'b00;
    tick();
    chk("t4_abort_rd", 64'(sd_rd), 64'd0);
    chk("t4_abort_busy", 64'(busy), 64'd0);
    req_rd = 2'b11;
    tick();
    chk("t4_regrant0", 64'(grant_idx), 64'd0);
    sd_ack = 1'b1;
    tick();
    req_rd = 2'b00; sd_ack = 1'b0;
    tick();

    // stray ack while idle
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    #1;
    chk("t5_buff_wr", 64'(req_buff_wr), 64'd0);
    tick();
    chk("t5_req_ack", 64'(req_ack), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    tick();
    chk("t5_busy2", 64'(busy), 64'd0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();

    // reset mid-transfer, bridge ack still high afterwards
    req_rd = 2'b01;
    tick();
    sd_ack = 1'b1;
    tick();
    req_rd = 2'b00;
    chk("t6_req_ack", 64'(req_ack), 64'b01);
    for (int i = 0; i < 100; i++) begin
      sd_buff_wr = 1'b1;
      sd_buff_addr = 9'(i);
      tick();
    end
    reset = 1'b1;
    #1;
    chk("t6_rst_ack", 64'(req_ack), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rd", 64'(sd_rd | sd_wr), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t6_post_ack", 64'(req_ack), 64'd0);
    chk("t6_post_busy", 64'(busy), 64'd0);
    chk("t6_post_bwr", 64'(req_buff_wr), 64'd0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();

    // randomized traffic, checked every cycle by the model
    repeat (3000) begin
      tick();
      for (int i = 0; i < NUM; i++) begin
        bm = 2'(1 << i);
        if (((req_rd | req_wr) & bm) != 2'b00) begin
          if (((m_ack & bm) != 2'b00) || $urandom_range(0, 39) == 0) begin
            req_rd = req_rd & ~bm;
            req_wr = req_wr & ~bm;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          kind = int'($urandom_range(0, 2));
          if (kind != 1) req_rd = req_rd | bm;
          if (kind != 0) req_wr = req_wr | bm;
          req_lba = (req_lba & ~(64'hFFFF_FFFF << (32 * i))) | (64'($urandom) << (32 * i));
        end
      end
      if (!sd_ack) begin
        if ((m_rd || m_wr) && $urandom_range(0, 2) == 0) sd_ack = 1'b1;
        else if (m_st == 0 && $urandom_range(0, 24) == 0) sd_ack = 1'b1;
      end else if ($urandom_range(0, 5) == 0) begin
        sd_ack = 1'b0;
      end
      sd_buff_wr   = 1'($urandom_range(0, 1));
      sd_buff_addr = 9'($urandom);
      sd_buff_dout = 8'($urandom);
      req_buff_din = 16'($urandom);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Shares the single block-level SD access port of the HPS I/O bridge (sd_lba / sd_rd / sd_wr / sd_ack plus sector-buffer byte bus) among NUM virtual-drive requesters.
- Grants one transfer at a time, round-robin, and holds the grant for the whole sector.
- Routes ack and buffer writes only to the granted requester, and muxes that requester's write data back to the bridge.
- Sits between the core's drive controllers and hps_io.

Parameters:
NUM, 2, number of requesters (1..4)
AW, 8, MSB index of sector-buffer address (8 for byte mode, 7 for WIDE)
DW, 7, MSB index of sector-buffer data (7 for byte mode, 15 for WIDE)

Ports:
clk_sys  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req_lba  in  32*NUM  per-requester LBA, requester i at [32*i +:32]
req_rd  in  NUM  per-requester read request, level, held until its ack
req_wr  in  NUM  per-requester write request, level, held until its ack
req_ack  out  NUM  per-requester ack, one-hot or zero
req_buff_din  in  (DW+1)*NUM  per-requester buffer read data for writes
req_buff_addr  out  AW+1  broadcast buffer address
req_buff_dout  out  DW+1  broadcast buffer data
req_buff_wr  out  NUM  per-requester buffer write strobe, gated
sd_lba  out  32  to bridge
sd_rd  out  1  to bridge
sd_wr  out  1  to bridge
sd_ack  in  1  from bridge
sd_buff_addr  in  AW+1  from bridge
sd_buff_dout  in  DW+1  from bridge
sd_buff_wr  in  1  from bridge
sd_buff_din  out  DW+1  to bridge, granted requester's data
grant_idx  out  2  current/last granted requester
busy  out  1  high in any state but IDLE

Behaviour:
- Reset state (asynchronous): state=IDLE, sd_rd=0, sd_wr=0, sd_lba=0, req_ack=0, grant_idx=0, rr pointer=0, busy=0.
- States: IDLE, REQ, XFER.
- IDLE:
  - Candidate set is the requesters with req_rd|req_wr high.
  - The first candidate at or after (rr+1) mod NUM wins. After reset this means requester 1 has first priority when NUM>1.
  - On a win: latch grant_idx and sd_lba=req_lba[grant]. Set sd_rd=req_rd[grant]; set sd_wr=req_wr[grant]&~req_rd[grant] (read wins if both are set). Go to REQ.
  - Latency: request seen at edge n gives sd_rd/sd_wr high after edge n.
- REQ:
  - If sd_ack is high: clear sd_rd and sd_wr, set req_ack[grant]=1, go to XFER.
  - Else, if the granted requester dropped both rd and wr: abort. Clear sd_rd and sd_wr, return to IDLE; rr is not advanced.
  - sd_lba is frozen while in REQ.
- XFER:
  - req_ack[grant] follows sd_ack, registered with 1-cycle delay.
  - On sd_ack low: clear req_ack, set rr=grant_idx, go to IDLE. A new grant can issue one cycle later.
  - Requester request lines are ignored in XFER.
- Buffer path (combinational, no added latency):
  - req_buff_addr=sd_buff_addr and req_buff_dout=sd_buff_dout, always.
  - req_buff_wr[i]=sd_buff_wr & busy & (grant_idx==i).
  - sd_buff_din=req_buff_din slice of grant_idx.
- sd_ack high while in IDLE (stray or config ack) is ignored. No req_ack and no req_buff_wr are produced.
- NUM=1: the rr logic degenerates and requester 0 is always granted.
- busy is registered: (state!=IDLE).
- grant_idx holds its value after a transfer, so that late buffer reads mux correctly.
- Reset asserted mid-transfer returns all outputs to reset values immediately. The bridge's ack will then be ignored per the IDLE rule.

Test Plan:
1. Single read: req_rd[0]=1, req_lba0=0x00001234 → next cycle sd_rd=1, sd_lba=0x1234. sd_ack rises → sd_rd=0, req_ack=01. Bridge writes 512 bytes → only req_buff_wr[0] pulses, 512 times. Ack falls → req_ack=00, busy=0.
2. Contention: req_rd[0], req_rd[1] both set from reset → requester 1 is served first, then requester 0. Hold both continuously → grants alternate 1,0,1,0.
3. Write mux: req_wr[1]=1, req_buff_din1=0xA5, req_buff_din0=0x3C → sd_wr=1, and during XFER sd_buff_din=0xA5. Also: req_rd[1] and req_wr[1] both set → sd_rd=1, sd_wr=0.
4. Abort: grant requester 0, drop req_rd[0] before sd_ack → sd_rd=0 next cycle, IDLE. Next pending requester is arbitrated with rr unchanged.
5. Stray ack: sd_ack pulse while idle with sd_buff_wr activity → req_ack=0, req_buff_wr=0, state remains IDLE.
6. Reset in XFER: assert reset during byte 100 → sd_rd/sd_wr/req_ack/busy=0 asynchronously. After release, sd_ack still high → ignored until the next request.
